pipe_stage_reg: RTL and testbench

//   Generic inter-stage pipeline register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with valid/ready

---
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, a two-entry skid buffer, flush, and control zeroing on bubbles.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic deliver;

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign deliver  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || deliver) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                // Bubble: control is zeroed, payload keeps its last value.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!main_valid_q && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, back-pressure, flush, bubble, reset and statistics.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] EXP_STALL_SAT = 4'd15;
    localparam logic [CNT_W-1:0] EXP_BUBBLE    = 4'd2;
`else
    localparam logic [CNT_W-1:0] EXP_STALL_SAT = 4'd0;
    localparam logic [CNT_W-1:0] EXP_BUBBLE    = 4'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    function automatic logic [DATA_W-1:0] pl(input logic [CTRL_W-1:0] c);
        return {24'hD0D0D0, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = pl(c);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                              input logic [DATA_W-1:0] d, input logic rdy);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 8'hEE);
        step(); step();
        expect_out("reset", 1'b0, 8'h00, '0, 1'b1);
        check("reset.stall",  64'(stall_cnt),  64'd0);
        check("reset.bubble", 64'(bubble_cnt), 64'd0);

        // 1: streaming at full throughput
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h11 + i));
            step();
            expect_out($sformatf("stream%0d", i), 1'b1, 8'(8'h11 + i), pl(8'(8'h11 + i)), 1'b1);
        end
        drive(1'b0, 8'h00);
        step();
        expect_out("stream_end", 1'b0, 8'h00, pl(8'h15), 1'b1);

        // 2: back-pressure fills skid, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 8'h21);
        step();
        expect_out("bp_main", 1'b1, 8'h21, pl(8'h21), 1'b1);
        drive(1'b1, 8'h22);
        step();
        expect_out("bp_skid", 1'b1, 8'h21, pl(8'h21), 1'b0);
        drive(1'b0, 8'h00);
        step();
        expect_out("bp_hold", 1'b1, 8'h21, pl(8'h21), 1'b0);
        out_ready = 1'b1;
        step();
        expect_out("bp_drain1", 1'b1, 8'h22, pl(8'h22), 1'b1);
        step();
        expect_out("bp_drain2", 1'b0, 8'h00, pl(8'h22), 1'b1);

        // 3: flush with both entries full; a flush-cycle accept is dropped
        out_ready = 1'b0;
        drive(1'b1, 8'h31); step();
        drive(1'b1, 8'h32); step();
        check("fl_full.ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 8'h33);
        step();
        expect_out("flush1", 1'b0, 8'h00, pl(8'h31), 1'b1);
        drive(1'b1, 8'h34);
        step();
        expect_out("flush2", 1'b0, 8'h00, pl(8'h31), 1'b1);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00);
        step();
        expect_out("flush_after", 1'b0, 8'h00, pl(8'h31), 1'b1);

        // 4: single bubble between two entries
        drive(1'b1, 8'h41); step();
        expect_out("bub_a", 1'b1, 8'h41, pl(8'h41), 1'b1);
        drive(1'b0, 8'h00); step();
        expect_out("bub_gap", 1'b0, 8'h00, pl(8'h41), 1'b1);
        drive(1'b1, 8'h42); step();
        expect_out("bub_b", 1'b1, 8'h42, pl(8'h42), 1'b1);

        // 5: reset mid-stream with skid full; flush and inputs ignored during reset
        out_ready = 1'b0;
        drive(1'b1, 8'h51); step();
        drive(1'b1, 8'h52); step();
        check("rst_pre.ready", 64'(in_ready), 64'd0);
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 8'h53);
        step();
        expect_out("rst_mid", 1'b0, 8'h00, '0, 1'b1);
        check("rst_mid.stall",  64'(stall_cnt),  64'd0);
        check("rst_mid.bubble", 64'(bubble_cnt), 64'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 8'h54); step();
        expect_out("rst_post", 1'b1, 8'h54, pl(8'h54), 1'b1);
        drive(1'b0, 8'h00); step();
        expect_out("rst_drain", 1'b0, 8'h00, pl(8'h54), 1'b1);

        // 6: stall counter saturation, survives flush
        out_ready = 1'b0;
        drive(1'b1, 8'h61); step();
        drive(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) step();
        expect_out("stat_hold", 1'b1, 8'h61, pl(8'h61), 1'b1);
        check("stat.stall",  64'(stall_cnt),  64'(EXP_STALL_SAT));
        check("stat.bubble", 64'(bubble_cnt), 64'(EXP_BUBBLE));
        flush = 1'b1; step();
        flush = 1'b0;
        check("stat_flush.stall", 64'(stall_cnt), 64'(EXP_STALL_SAT));
        check("stat_flush.valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
